serial_to_parallel: RTL
=======================

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of serial bits per parallel word; legal values are 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port serial_valid, input, 1 bit: serial_data carries a valid bit this cycle.
REQ-005 The block SHALL have port serial_data, input, 1 bit: serial bit, LSB first.
REQ-006 The block SHALL have port serial_ready, output, 1 bit: the block accepts a serial bit this cycle.
REQ-007 The block SHALL have port parallel_valid, output, 1 bit: parallel_data holds a completed word.
REQ-008 The block SHALL have port parallel_data, output, WIDTH bits: assembled word; bit k is the k-th accepted serial bit.
REQ-009 The block SHALL have port parallel_ready, input, 1 bit: the downstream consumer takes the word this cycle.

Function
REQ-010 A serial bit SHALL be accepted in a cycle exactly when serial_valid and serial_ready are both 1.
REQ-011 The block SHALL keep a bit counter cnt of width $clog2(WIDTH) and a WIDTH-bit shift register.
- Each accepted bit is written to shift position cnt.
- cnt increments by 1 on each accepted bit.
- cnt wraps from WIDTH-1 to 0.
REQ-012 Accepting the bit at cnt == WIDTH-1 SHALL complete a word.
- On that edge, parallel_data is loaded with the full word, including the just-accepted bit.
- parallel_valid is set to 1.
- Latency is one cycle from the last bit accepted to parallel_valid high.
REQ-013 A word SHALL be consumed in a cycle exactly when parallel_valid and parallel_ready are both 1.
- parallel_valid is cleared on that edge unless a new word completes on the same edge.
- If a new word completes on the same edge, parallel_valid stays 1 and parallel_data takes the new word.
REQ-014 While parallel_valid is 1 and parallel_ready is 0, parallel_data and parallel_valid SHALL hold unchanged.
REQ-015 serial_ready SHALL be 0 exactly when all three hold; otherwise it is 1:
- cnt == WIDTH-1,
- parallel_valid == 1,
- parallel_ready == 0.
REQ-016 serial_ready SHALL be combinational from cnt, parallel_valid and parallel_ready, and SHALL NOT depend on serial_valid.
REQ-017 Collection of the next word SHALL proceed while a previous word is held, so with continuous serial_valid and parallel_ready there is no gap:
- one word every WIDTH cycles,
- serial_ready constantly 1.
REQ-018 Cycles with serial_valid == 0 SHALL leave cnt and the shift register unchanged; gaps may occur at any bit position.
REQ-019 serial_data SHALL be ignored when serial_valid or serial_ready is 0.
REQ-020 parallel_data SHALL change only on word completion or reset, never on partial accumulation.

Reset
REQ-021 While rst is 1, irrespective of clk, the block SHALL hold:
- cnt = 0,
- shift register = 0,
- parallel_data = 0,
- parallel_valid = 0.
REQ-022 Reset asserted mid-word or with a word pending SHALL discard the partial and pending data; the first bit accepted after rst falls is bit 0 of a new word.
REQ-023 serial_ready SHALL be 1 during and immediately after reset.

Verification
REQ-024 WIDTH=8; rst pulse; then bits 1,0,1,0,0,1,0,1 on consecutive cycles, parallel_ready=1 -> one cycle after the 8th bit, parallel_valid=1 and parallel_data=8'hA5; parallel_valid=0 on the following cycle.
REQ-025 Same bits as REQ-024 with serial_valid=0 on every other cycle -> parallel_data=8'hA5 after 16 cycles; no intermediate parallel_valid.
REQ-026 Backpressure: parallel_ready=0, stream 16 bits for words 8'h3C then 8'hC3 -> 8'h3C held; after 15 bits accepted, serial_ready=0 and the 16th bit stalls; raising parallel_ready releases 8'h3C, then 8'hC3 appears the next cycle, with no bit lost.
REQ-027 Continuous stream of 3 words 8'h01, 8'hFF, 8'h80 with parallel_ready=1 -> parallel_valid high for exactly 1 cycle every 8 cycles; words in order.
REQ-028 Assert rst asynchronously after 5 bits of a word (mid-clock) -> outputs zero immediately; the next 8 bits 8'h5A yield parallel_data=8'h5A.
REQ-029 WIDTH=2 instance; bits 1,1,0,1 -> words 2'b11 then 2'b10.

Source files
------------

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel converter: assembles WIDTH LSB-first serial bits into a word
// with valid/ready handshakes on both sides and no bubble between consecutive words.
module serial_to_parallel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             serial_ready,
  output logic             parallel_valid,
  output logic [WIDTH-1:0] parallel_data,
  input  logic             parallel_ready
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt_q == LAST);

  // Only the word-completing bit must stall, and only while the held word cannot leave.
  assign serial_ready = !(last_bit && vld_q && !parallel_ready);
  assign accept       = serial_valid && serial_ready;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = vld_q;
    if (accept) begin
      shift_d[cnt_q] = serial_data;
      cnt_d          = last_bit ? '0 : cnt_q + CNT_W'(1);
    end
    // Completion takes priority over consumption so a back-to-back word keeps valid high.
    if (accept && last_bit) begin
      data_d = shift_d;
      vld_d  = 1'b1;
    end else if (vld_q && parallel_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign parallel_valid = vld_q;
  assign parallel_data  = data_q;

endmodule
